risc_trace_ctrl: RTL and testbench
==================================

RISC_TRACE_CTRL -- requirements
Module: risc_trace_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of instruction and write-data fields.
REQ-002 Parameter ADDR_W, default 32, width of PC field.
REQ-003 Parameter DEPTH, default 16, trace entries; power of two, >=2.
REQ-004 Parameter RST_CYCLES, default 1, core reset pulse length in clk cycles, >=1.
REQ-005 Parameter MAX_CYCLES, default 10, run budget in clk cycles, >=1.
REQ-006 Parameter STALL_LIMIT, default 4, consecutive unchanged-PC cycles declaring halt, >=1.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-010 pc_i  in  ADDR_W  core instruction address.
REQ-011 instr_i  in  DATA_W  core fetched instruction.
REQ-012 wdata_i  in  DATA_W  core register write data.
REQ-013 rd_en  in  1  pop oldest trace entry.
REQ-014 core_rst  out  1  active-high reset driven to the core.
REQ-015 running  out  1  high in RUN.
REQ-016 done  out  1  high in DONE.
REQ-017 halt_det  out  1  sticky; run ended by PC stall.
REQ-018 timeout  out  1  sticky; run ended by budget.
REQ-019 overflow  out  1  sticky; trace entry overwritten.
REQ-020 cycle_cnt  out  32  RUN cycles elapsed.
REQ-021 count  out  log2(DEPTH)+1  valid trace entries.
REQ-022 rd_valid  out  1  rd_pc/rd_instr/rd_wdata valid this cycle.
REQ-023 rd_pc, rd_instr, rd_wdata  out  ADDR_W/DATA_W/DATA_W  popped entry.

Function
REQ-024 FSM states SHALL be IDLE, RESET, RUN, DONE; core_rst SHALL be 1 in every state except RUN.
REQ-025 IDLE or DONE + start SHALL go to RESET next cycle, clearing count, pointers, cycle_cnt, halt_det, timeout, overflow, stall counter.
REQ-026 RESET SHALL last exactly RST_CYCLES cycles, then go to RUN.
REQ-027 Each RUN cycle SHALL write {pc_i,instr_i,wdata_i} at write pointer and increment cycle_cnt by 1.
REQ-028 Write with count==DEPTH SHALL overwrite oldest entry, advance read pointer, hold count at DEPTH, set overflow.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 Stall counter SHALL increment when pc_i equals previous RUN-cycle pc_i, else clear; first RUN cycle counts as change.
REQ-031 Stall counter reaching STALL_LIMIT SHALL set halt_det and go to DONE next cycle.
REQ-032 cycle_cnt reaching MAX_CYCLES SHALL set timeout and go to DONE next cycle.
REQ-033 Halt and budget in same cycle SHALL set both halt_det and timeout.
REQ-034 The cycle causing exit SHALL still be captured.
REQ-035 In DONE, rd_en with count>0 SHALL pop oldest entry: rd_valid=1 and data valid on the following cycle, count decremented.
REQ-036 rd_en with count==0, or outside DONE, SHALL be ignored; rd_valid=0.
REQ-037 rd_valid SHALL be a single-cycle pulse per accepted pop; rd_* data holds last popped value otherwise.
REQ-038 start during RESET or RUN SHALL be ignored.

Reset
REQ-039 rst low SHALL immediately force IDLE, core_rst=1, all other outputs 0, count=0, cycle_cnt=0, regardless of state.
REQ-040 Trace storage contents need not be reset.

Verification
REQ-041 Defaults, start, pc_i increments by 4 each cycle -> core_rst 1 for 1 cycle, RUN 10 cycles, timeout=1, halt_det=0, count=10, cycle_cnt=10.
REQ-042 pc_i constant 0x20 from 3rd RUN cycle -> halt_det=1 after 5 more cycles (stall reaches 4), done=1, timeout=0.
REQ-043 DEPTH=4, MAX_CYCLES=10, distinct PCs 0..36 -> overflow=1, count=4, pops return PCs 24,28,32,36, 5th rd_en gives rd_valid=0.
REQ-044 MAX_CYCLES=4, STALL_LIMIT=3, pc_i constant -> halt_det=1 and timeout=1 same cycle.
REQ-045 rst low mid-RUN at cycle 5 -> same-cycle IDLE, core_rst=1, count=0; subsequent start runs clean.
REQ-046 start in DONE after partial readout -> RESET, count=0, flags cleared, new run captured.

Source files
------------

// File: rtl/risc_trace_ctrl.sv
// risc_trace_ctrl
// ---------------
// Drives a RISC core through a bounded run and records a per-cycle trace of
// its fetch address, fetched instruction and register write data.
//
// Run sequence: IDLE --start--> RESET (core held in reset for RST_CYCLES)
// --> RUN (one trace entry per cycle) --> DONE (run ended by a PC stall, by
// the cycle budget, or both). In DONE the trace is read back oldest-first
// with rd_en. A new start from DONE discards the old trace and runs again.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   start                 one-cycle pulse, honoured in IDLE or DONE only
//   pc_i, instr_i, wdata_i  core signals sampled every RUN cycle
//   rd_en                 pop the oldest trace entry (DONE only)
//   core_rst              active-high reset to the core (low only in RUN)
//   running, done         state indicators for RUN and DONE
//   halt_det, timeout     sticky run-exit causes (PC stall / cycle budget)
//   overflow              sticky: an entry was overwritten by a newer one
//   cycle_cnt             RUN cycles elapsed in the current run
//   count                 valid entries currently held
//   rd_valid              one-cycle pulse; rd_pc/rd_instr/rd_wdata hold the
//                         popped entry (and keep it until the next pop)
module risc_trace_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int RST_CYCLES  = 1,
  parameter int MAX_CYCLES  = 10,
  parameter int STALL_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [DATA_W-1:0]        instr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     rd_en,
  output logic                     core_rst,
  output logic                     running,
  output logic                     done,
  output logic                     halt_det,
  output logic                     timeout,
  output logic                     overflow,
  output logic [31:0]              cycle_cnt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rd_valid,
  output logic [ADDR_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [31:0]       rst_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [31:0]       stall_cnt;
  logic [ADDR_W-1:0] prev_pc;
  logic              first_run;

  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];

  logic        full;
  logic        pop_ok;
  logic [31:0] stall_nxt;
  logic [31:0] cycle_nxt;
  logic        hit_halt;
  logic        hit_budget;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    stall_nxt = 32'd0;
    if (!first_run && (pc_i == prev_pc)) begin
      stall_nxt = stall_cnt + 32'd1;
    end
    cycle_nxt  = cycle_cnt + 32'd1;
    hit_halt   = (stall_nxt >= 32'(STALL_LIMIT));
    hit_budget = (cycle_nxt >= 32'(MAX_CYCLES));
    full       = (count == CNT_W'(DEPTH));
    // A start in DONE wins over a simultaneous pop: the trace is discarded.
    pop_ok     = (state == S_DONE) && rd_en && (count != '0) && !start;
  end

  assign core_rst = (state != S_RUN);
  assign running  = (state == S_RUN);
  assign done     = (state == S_DONE);

  // NOTE: trace storage has no reset; count and the pointers define which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (state == S_RUN) begin
      mem_pc[wr_ptr]    <= pc_i;
      mem_instr[wr_ptr] <= instr_i;
      mem_wdata[wr_ptr] <= wdata_i;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rst_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
      prev_pc   <= '0;
      first_run <= 1'b1;
      cycle_cnt <= '0;
      halt_det  <= 1'b0;
      timeout   <= 1'b0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_pc     <= '0;
      rd_instr  <= '0;
      rd_wdata  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RESET;
            rst_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stall_cnt <= '0;
            first_run <= 1'b1;
            cycle_cnt <= '0;
            halt_det  <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
          end else if (pop_ok) begin
            rd_valid <= 1'b1;
            rd_pc    <= mem_pc[rd_ptr];
            rd_instr <= mem_instr[rd_ptr];
            rd_wdata <= mem_wdata[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
            count    <= count - 1'b1;
          end
        end

        S_RESET: begin
          if (rst_cnt == 32'(RST_CYCLES - 1)) begin
            state <= S_RUN;
          end else begin
            rst_cnt <= rst_cnt + 32'd1;
          end
        end

        S_RUN: begin
          // The exiting cycle is still captured: the write happens
          // unconditionally here, and the state change takes effect after.
          wr_ptr    <= wr_ptr + 1'b1;
          cycle_cnt <= cycle_nxt;
          stall_cnt <= stall_nxt;
          prev_pc   <= pc_i;
          first_run <= 1'b0;
          if (full) begin
            // Oldest entry is overwritten: drop it by advancing the reader.
            rd_ptr   <= rd_ptr + 1'b1;
            overflow <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
          if (hit_halt) begin
            halt_det <= 1'b1;
          end
          if (hit_budget) begin
            timeout <= 1'b1;
          end
          if (hit_halt || hit_budget) begin
            state <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_trace_ctrl.sv
// Bench for risc_trace_ctrl. Three instances with different parameter sets
// share one stimulus stream; a queue-based reference model per instance
// predicts every output each cycle, and directed checks pin the documented
// scenarios to fixed expected values.
module tb_risc_trace_ctrl;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [31:0] wdata = '0;
  logic        rd_en = 1'b0;

  logic        core_rst_w [N];
  logic        running_w  [N];
  logic        done_w     [N];
  logic        halt_w     [N];
  logic        to_w       [N];
  logic        ovf_w      [N];
  logic        rdv_w      [N];
  logic [31:0] cyc_w      [N];
  logic [31:0] rpc_w      [N];
  logic [31:0] rinstr_w   [N];
  logic [31:0] rwdata_w   [N];
  logic [4:0]  cnt0;
  logic [2:0]  cnt1;
  logic [3:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic int p_depth(input int i);
    case (i)
      0:       return 16;
      1:       return 4;
      default: return 8;
    endcase
  endfunction
  function automatic int p_rst(input int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int p_max(input int i);
    return (i == 2) ? 4 : 10;
  endfunction
  function automatic int p_stall(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  risc_trace_ctrl u0 (
    .clk(clk), .rst(rst), .start(start), .pc_i(pc), .instr_i(instr),
    .wdata_i(wdata), .rd_en(rd_en), .core_rst(core_rst_w[0]),
    .running(running_w[0]), .done(done_w[0]), .halt_det(halt_w[0]),
    .timeout(to_w[0]), .overflow(ovf_w[0]), .cycle_cnt(cyc_w[0]),
    .count(cnt0), .rd_valid(rdv_w[0]), .rd_pc(rpc_w[0]),
    .rd_instr(rinstr_w[0]), .rd_wdata(rwdata_w[0])
  );

  risc_trace_ctrl #(.DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .pc_i(pc), .instr_i(instr),
    .wdata_i(wdata), .rd_en(rd_en), .core_rst(core_rst_w[1]),
    .running(running_w[1]), .done(done_w[1]), .halt_det(halt_w[1]),
    .timeout(to_w[1]), .overflow(ovf_w[1]), .cycle_cnt(cyc_w[1]),
    .count(cnt1), .rd_valid(rdv_w[1]), .rd_pc(rpc_w[1]),
    .rd_instr(rinstr_w[1]), .rd_wdata(rwdata_w[1])
  );

  risc_trace_ctrl #(.DEPTH(8), .RST_CYCLES(2), .MAX_CYCLES(4), .STALL_LIMIT(3)) u2 (
    .clk(clk), .rst(rst), .start(start), .pc_i(pc), .instr_i(instr),
    .wdata_i(wdata), .rd_en(rd_en), .core_rst(core_rst_w[2]),
    .running(running_w[2]), .done(done_w[2]), .halt_det(halt_w[2]),
    .timeout(to_w[2]), .overflow(ovf_w[2]), .cycle_cnt(cyc_w[2]),
    .count(cnt2), .rd_valid(rdv_w[2]), .rd_pc(rpc_w[2]),
    .rd_instr(rinstr_w[2]), .rd_wdata(rwdata_w[2])
  );

  function automatic logic [63:0] dut_count(input int i);
    case (i)
      0:       return 64'(cnt0);
      1:       return 64'(cnt1);
      default: return 64'(cnt2);
    endcase
  endfunction

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RESET, M_RUN, M_DONE} mstate_t;

  mstate_t     m_st    [N];
  int          m_rc    [N];
  logic [95:0] m_q     [N][$];
  int          m_cyc   [N];
  int          m_stall [N];
  logic [31:0] m_prev  [N];
  bit          m_have  [N];
  bit          m_halt  [N];
  bit          m_to    [N];
  bit          m_ovf   [N];
  bit          m_rdv   [N];
  logic [31:0] m_rpc   [N];
  logic [31:0] m_rinstr[N];
  logic [31:0] m_rwdata[N];

  task automatic model_reset(input int i);
    m_st[i] = M_IDLE;
    m_rc[i] = 0;
    m_q[i].delete();
    m_cyc[i] = 0;
    m_stall[i] = 0;
    m_prev[i] = '0;
    m_have[i] = 0;
    m_halt[i] = 0;
    m_to[i] = 0;
    m_ovf[i] = 0;
    m_rdv[i] = 0;
    m_rpc[i] = '0;
    m_rinstr[i] = '0;
    m_rwdata[i] = '0;
  endtask

  task automatic model_step(input int i);
    logic [95:0] e;
    m_rdv[i] = 0;
    case (m_st[i])
      M_IDLE, M_DONE: begin
        if (start) begin
          m_st[i] = M_RESET;
          m_rc[i] = 0;
          m_q[i].delete();
          m_cyc[i] = 0;
          m_stall[i] = 0;
          m_have[i] = 0;
          m_halt[i] = 0;
          m_to[i] = 0;
          m_ovf[i] = 0;
        end else if (m_st[i] == M_DONE && rd_en && m_q[i].size() > 0) begin
          e = m_q[i].pop_front();
          m_rdv[i] = 1;
          m_rpc[i] = e[95:64];
          m_rinstr[i] = e[63:32];
          m_rwdata[i] = e[31:0];
        end
      end
      M_RESET: begin
        m_rc[i]++;
        if (m_rc[i] >= p_rst(i)) m_st[i] = M_RUN;
      end
      M_RUN: begin
        m_q[i].push_back({pc, instr, wdata});
        if (m_q[i].size() > p_depth(i)) begin
          m_q[i].delete(0);
          m_ovf[i] = 1;
        end
        m_cyc[i]++;
        if (m_have[i] && pc == m_prev[i]) m_stall[i]++;
        else m_stall[i] = 0;
        m_prev[i] = pc;
        m_have[i] = 1;
        if (m_stall[i] >= p_stall(i)) m_halt[i] = 1;
        if (m_cyc[i] >= p_max(i)) m_to[i] = 1;
        if (m_halt[i] || m_to[i]) m_st[i] = M_DONE;
      end
      default: m_st[i] = M_IDLE;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) model_reset(i);
      else model_step(i);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d.core_rst", i), 64'(core_rst_w[i]), 64'(m_st[i] != M_RUN));
      check($sformatf("u%0d.running", i),  64'(running_w[i]),  64'(m_st[i] == M_RUN));
      check($sformatf("u%0d.done", i),     64'(done_w[i]),     64'(m_st[i] == M_DONE));
      check($sformatf("u%0d.halt_det", i), 64'(halt_w[i]),     64'(m_halt[i]));
      check($sformatf("u%0d.timeout", i),  64'(to_w[i]),       64'(m_to[i]));
      check($sformatf("u%0d.overflow", i), 64'(ovf_w[i]),      64'(m_ovf[i]));
      check($sformatf("u%0d.cycle_cnt", i), 64'(cyc_w[i]),     64'(m_cyc[i]));
      check($sformatf("u%0d.count", i),    dut_count(i),       64'(m_q[i].size()));
      check($sformatf("u%0d.rd_valid", i), 64'(rdv_w[i]),      64'(m_rdv[i]));
      check($sformatf("u%0d.rd_pc", i),    64'(rpc_w[i]),      64'(m_rpc[i]));
      check($sformatf("u%0d.rd_instr", i), 64'(rinstr_w[i]),   64'(m_rinstr[i]));
      check($sformatf("u%0d.rd_wdata", i), 64'(rwdata_w[i]),   64'(m_rwdata[i]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit s, input logic [31:0] p, input bit r);
    start = s;
    pc    = p;
    rd_en = r;
    instr = $urandom;
    wdata = $urandom;
  endtask

  // Run from start with pc = 4*(k-2) at step k: with a one-cycle reset the
  // first RUN cycle sees pc 0.
  task automatic run_incrementing(input int steps);
    for (int s = 0; s < steps; s++) begin
      drive(s == 0, (s >= 2) ? 32'(4 * (s - 2)) : 32'd0, 1'b0);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    rst = 1'b0;
    tick();
    check("reset.core_rst", 64'(core_rst_w[0]), 64'd1);
    check("reset.count",    dut_count(0),       64'd0);
    check("reset.cycle_cnt", 64'(cyc_w[0]),     64'd0);
    rst = 1'b1;
    tick();

    // Budget-limited run with incrementing PCs; start and rd_en during RUN
    // are ignored.
    for (int s = 0; s < 16; s++) begin
      drive(s == 0 || s == 5, (s >= 2) ? 32'(4 * (s - 2)) : 32'd0, s == 3 || s == 4);
      tick();
    end
    check("A.u0.timeout",   64'(to_w[0]),   64'd1);
    check("A.u0.halt_det",  64'(halt_w[0]), 64'd0);
    check("A.u0.done",      64'(done_w[0]), 64'd1);
    check("A.u0.count",     dut_count(0),   64'd10);
    check("A.u0.cycle_cnt", 64'(cyc_w[0]),  64'd10);
    check("A.u0.overflow",  64'(ovf_w[0]),  64'd0);
    check("A.u1.overflow",  64'(ovf_w[1]),  64'd1);
    check("A.u1.count",     dut_count(1),   64'd4);
    check("A.u2.timeout",   64'(to_w[2]),   64'd1);
    check("A.u2.count",     dut_count(2),   64'd4);

    // Readout: DEPTH=4 instance returns the newest four PCs, then runs dry.
    for (int p = 0; p < 5; p++) begin
      drive(1'b0, 32'd0, 1'b1);
      tick();
      check($sformatf("pop%0d.u1.rd_valid", p), 64'(rdv_w[1]), 64'(p < 4));
      if (p < 4) check($sformatf("pop%0d.u1.rd_pc", p), 64'(rpc_w[1]), 64'(24 + 4 * p));
    end
    check("pop4.u0.rd_pc", 64'(rpc_w[0]), 64'd16);
    drive(1'b0, 32'd0, 1'b0);
    tick();
    check("hold.u1.rd_valid", 64'(rdv_w[1]), 64'd0);
    check("hold.u1.rd_pc",    64'(rpc_w[1]), 64'd36);
    check("hold.u0.count",    dut_count(0),  64'd5);

    // Restart from DONE after partial readout; PC sticks at 0x20 from the
    // third RUN cycle.
    drive(1'b1, 32'd0, 1'b0);
    tick();
    check("B.u0.count",    dut_count(0),      64'd0);
    check("B.u0.timeout",  64'(to_w[0]),      64'd0);
    check("B.u0.core_rst", 64'(core_rst_w[0]), 64'd1);
    check("B.u1.overflow", 64'(ovf_w[1]),     64'd0);
    for (int s = 1; s < 13; s++) begin
      drive(1'b0, (s == 2) ? 32'h18 : (s == 3) ? 32'h1c : (s >= 4) ? 32'h20 : 32'h0, 1'b0);
      tick();
    end
    check("B.u0.halt_det",  64'(halt_w[0]), 64'd1);
    check("B.u0.timeout",   64'(to_w[0]),   64'd0);
    check("B.u0.done",      64'(done_w[0]), 64'd1);
    check("B.u0.cycle_cnt", 64'(cyc_w[0]),  64'd7);
    check("B.u0.count",     dut_count(0),   64'd7);

    // Constant PC: halt and budget coincide on the small instance.
    for (int s = 0; s < 12; s++) begin
      drive(s == 0, 32'h100, 1'b0);
      tick();
    end
    check("C.u2.halt_det",  64'(halt_w[2]), 64'd1);
    check("C.u2.timeout",   64'(to_w[2]),   64'd1);
    check("C.u2.cycle_cnt", 64'(cyc_w[2]),  64'd4);
    check("C.u0.halt_det",  64'(halt_w[0]), 64'd1);
    check("C.u0.timeout",   64'(to_w[0]),   64'd0);
    check("C.u0.cycle_cnt", 64'(cyc_w[0]),  64'd5);

    // Reset in the middle of a run, then a clean run.
    run_incrementing(7);
    check("D.u0.cycle_cnt_pre", 64'(cyc_w[0]), 64'd5);
    #2 rst = 1'b0;
    #1;
    check("D.u0.core_rst",  64'(core_rst_w[0]), 64'd1);
    check("D.u0.running",   64'(running_w[0]),  64'd0);
    check("D.u0.count",     dut_count(0),       64'd0);
    check("D.u0.cycle_cnt", 64'(cyc_w[0]),      64'd0);
    check("D.u2.done",      64'(done_w[2]),     64'd0);
    tick();
    rst = 1'b1;
    tick();
    run_incrementing(14);
    check("D2.u0.count",     dut_count(0),   64'd10);
    check("D2.u0.cycle_cnt", 64'(cyc_w[0]),  64'd10);
    check("D2.u0.timeout",   64'(to_w[0]),   64'd1);
    check("D2.u0.halt_det",  64'(halt_w[0]), 64'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] npc;
      case ($urandom_range(0, 3))
        0, 1:    npc = pc;
        2:       npc = pc + 32'd4;
        default: npc = 32'($urandom_range(0, 3) * 4);
      endcase
      drive($urandom_range(0, 24) == 0, npc, 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
